// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct encodings, control FSM state codes and ALU
// operation type for the multicycle MIPS core.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Control FSM state codes
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

endpackage

// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm: multicycle control. Holds the state register, decodes the
// instruction register fields and drives datapath selects and memory handshake.
// beq/j support is compiled in only when MIPS_BRANCH_EN is defined.
module mips_ctrl_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic [3:0] state,
  output alu_op_e    alu_op,
  output logic       alu_src_imm,
  output logic       reg_write,
  output logic       reg_dst_rd,
  output logic       wb_from_mem,
  output logic       mem_req,
  output logic       mem_we,
  output logic       retired,
  output logic       illegal_op
);

  logic [3:0] state_next;
  logic [3:0] decode_next;
  logic       decode_illegal;
  logic       legal_r;
  alu_op_e    r_op;

  // Map the R-type funct field to an ALU operation and flag unknown functs
  always_comb begin
    legal_r = 1'b1;
    r_op    = ALU_ADD;
    case (funct)
      FN_ADD:  r_op = ALU_ADD;
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_SLT:  r_op = ALU_SLT;
      default: legal_r = 1'b0;
    endcase
  end

  // Choose the execute state for the opcode; anything unknown goes back to fetch
  always_comb begin
    decode_next    = S_FETCH;
    decode_illegal = 1'b1;
    case (opcode)
      OP_RTYPE: if (legal_r) begin
        decode_next    = S_EXEC_R;
        decode_illegal = 1'b0;
      end
      OP_ADDI: begin
        decode_next    = S_EXEC_I;
        decode_illegal = 1'b0;
      end
      OP_LW, OP_SW: begin
        decode_next    = S_MEM_ADDR;
        decode_illegal = 1'b0;
      end
`ifdef MIPS_BRANCH_EN
      OP_BEQ: begin
        decode_next    = S_BRANCH;
        decode_illegal = 1'b0;
      end
      OP_J: begin
        decode_next    = S_JUMP;
        decode_illegal = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic; memory states stall until the access completes
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:            if (mem_ready) state_next = S_DECODE;
      S_DECODE:           state_next = decode_next;
      S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
      S_MEM_ADDR:         state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:           if (mem_ready) state_next = S_WB_MEM;
      S_MEM_WR:           if (mem_ready) state_next = S_FETCH;
      default:            state_next = S_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Datapath selects and status; reset masks all externally visible strobes
  always_comb begin
    alu_op      = (state == S_EXEC_R) ? r_op : ALU_ADD;
    alu_src_imm = (state != S_EXEC_R);
    reg_write   = (state == S_WB_ALU) || (state == S_WB_MEM);
    reg_dst_rd  = (opcode == OP_RTYPE);
    wb_from_mem = (state == S_WB_MEM);
    mem_req     = !reset && ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR));
    mem_we      = !reset && (state == S_MEM_WR);
    illegal_op  = !reset && (state == S_DECODE) && decode_illegal;
    retired     = !reset && ((state == S_WB_ALU) || (state == S_WB_MEM) ||
                             ((state == S_MEM_WR) && mem_ready) ||
                             (state == S_BRANCH) || (state == S_JUMP) ||
                             ((state == S_DECODE) && decode_illegal));
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS integer subset over a single unified
// req/ready word memory. Register file, ALU and sign extension live here;
// sequencing comes from mips_ctrl_fsm. Define MIPS_BRANCH_EN to add beq and j.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NREGS      = 32,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  retired,
  output logic                  illegal_op,
  output logic [ADDR_WIDTH+1:0] pc_o
);

  localparam int PC_W = ADDR_WIDTH + 2;
  localparam int RW   = $clog2(NREGS);
  localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_PC);

  logic [PC_W-1:0]       pc;
  logic [31:0]           ir;
  logic [DATA_WIDTH-1:0] a_reg, b_reg, alu_out, mdr;
  logic [DATA_WIDTH-1:0] regs [NREGS];

  logic [3:0]            state;
  alu_op_e               alu_op;
  logic                  alu_src_imm, reg_write, reg_dst_rd, wb_from_mem;
  logic [RW-1:0]         rs, rt, rd, wr_idx;
  logic [DATA_WIDTH-1:0] imm_ext, alu_b, alu_result, rd_a, rd_b;
  logic                  unused_bits;

  mips_ctrl_fsm u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .opcode      (ir[31:26]),
    .funct       (ir[5:0]),
    .mem_ready   (mem_ready),
    .state       (state),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .reg_write   (reg_write),
    .reg_dst_rd  (reg_dst_rd),
    .wb_from_mem (wb_from_mem),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .retired     (retired),
    .illegal_op  (illegal_op)
  );

  assign rs      = ir[21 +: RW];
  assign rt      = ir[16 +: RW];
  assign rd      = ir[11 +: RW];
  assign wr_idx  = reg_dst_rd ? rd : rt;
  assign imm_ext = {{(DATA_WIDTH-16){ir[15]}}, ir[15:0]};
  assign rd_a    = (rs == '0) ? '0 : regs[rs];
  assign rd_b    = (rt == '0) ? '0 : regs[rt];

  assign mem_addr  = (state == S_FETCH) ? pc[PC_W-1:2] : alu_out[ADDR_WIDTH+1:2];
  assign mem_wdata = b_reg;
  assign pc_o      = pc;

`ifdef MIPS_BRANCH_EN
  logic [DATA_WIDTH-1:0] br_off;
  logic [31:0]           jump_target;
  assign br_off      = imm_ext << 2;
  assign jump_target = (32'(pc) & 32'hF000_0000) | {4'b0000, ir[25:0], 2'b00};
  assign unused_bits = ^{ir[10:6], br_off, jump_target};
`else
  assign unused_bits = ^ir[10:6];
`endif

  // ALU: wrapping arithmetic, logic ops and signed set-less-than
  always_comb begin
    alu_b      = alu_src_imm ? imm_ext : b_reg;
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = a_reg + alu_b;
      ALU_SUB: alu_result = a_reg - alu_b;
      ALU_AND: alu_result = a_reg & alu_b;
      ALU_OR:  alu_result = a_reg | alu_b;
      ALU_SLT: alu_result = DATA_WIDTH'($signed(a_reg) < $signed(alu_b));
      default: alu_result = a_reg + alu_b;
    endcase
  end

  // Datapath registers and register file, advanced per FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= PC_RESET;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir <= 32'(mem_rdata);
          pc <= pc + PC_W'(4);
        end
        S_DECODE: begin
          a_reg <= rd_a;
          b_reg <= rd_b;
        end
        S_EXEC_R, S_EXEC_I, S_MEM_ADDR: alu_out <= alu_result;
        S_MEM_RD: if (mem_ready) mdr <= mem_rdata;
`ifdef MIPS_BRANCH_EN
        S_BRANCH: if (a_reg == b_reg) pc <= pc + br_off[PC_W-1:0];
        S_JUMP:   pc <= jump_target[PC_W-1:0];
`endif
        default: ;
      endcase
      if (reg_write && (wr_idx != '0))
        regs[wr_idx] <= wb_from_mem ? mdr : alu_out;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed programs with hand-computed results.
// Stimulus loads memory and queues one expectation per instruction; a monitor
// pops and compares on every retire. Register contents are observed via sw.
module tb_mips_multicycle_core;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int PW = AW + 2;
  localparam logic [31:0] NOP = 32'h2000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req, mem_we, mem_ready, retired, illegal_op;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [PW-1:0] pc_o;

  mips_multicycle_core #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NREGS(32), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .retired(retired), .illegal_op(illegal_op), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          illegal;
    logic [PW-1:0] pc;
    int            lat;
    logic          is_st;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [256];
  int          data_delay = 0;
  int          wait_cnt = 0;
  logic        next_is_fetch = 1'b1;
  int          cyc = 0;
  int          last_mark = 0;
  int          cur_delay;
  int          n_checks = 0;
  int          n_pass = 0;

  // Memory model: fetches are zero-wait, data accesses wait data_delay cycles
  always_comb begin
    cur_delay = next_is_fetch ? 0 : data_delay;
    mem_ready = mem_req && (wait_cnt >= cur_delay);
    mem_rdata = mem[mem_addr];
  end

  // Wait counter, fetch/data tracking and cycle count
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      wait_cnt      <= 0;
      next_is_fetch <= 1'b1;
    end else begin
      if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
      else                       wait_cnt <= 0;
      if (retired)                                  next_is_fetch <= 1'b1;
      else if (mem_req && mem_ready && next_is_fetch) next_is_fetch <= 1'b0;
    end
  end

  // Store completion into the memory array
  always @(posedge clk) begin
    if (!reset && mem_req && mem_we && mem_ready) mem[mem_addr] = mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic loadNops();
    for (int i = 0; i < 256; i++) mem[i] = NOP;
  endtask

  task automatic applyStimulus(input int baddr, input logic [31:0] instr, input logic illegal,
                               input int next_pc, input int lat, input logic is_st,
                               input int st_baddr, input logic [31:0] wdata);
    exp_t e;
    mem[baddr >> 2] = instr;
    e.illegal = illegal;
    e.pc      = PW'(next_pc);
    e.lat     = lat;
    e.is_st   = is_st;
    e.waddr   = AW'(st_baddr >> 2);
    e.wdata   = wdata;
    exp_q.push_back(e);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset     = 1'b0;
    last_mark = cyc - 1;
  endtask

  task automatic waitDrain(input string phase);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("[TB] FAIL %s_timeout: %0d retires outstanding, required 0", phase, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic enterReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: compare each retire against the next queued expectation
  initial begin
    exp_t          e;
    logic          pc_pending = 1'b0;
    logic [PW-1:0] pc_exp = '0;
    logic          prev_wait = 1'b0;
    logic          prev_reset = 1'b1;
    logic [AW-1:0] prev_addr = '0;
    forever begin
      @(negedge clk);
      if (pc_pending) begin
        checkOutput("pc_after_retire", 32'(pc_o), 32'(pc_exp));
        pc_pending = 1'b0;
      end
      if (prev_wait && !prev_reset && !reset) begin
        checkOutput("mem_req_held", 32'(mem_req), 32'd1);
        checkOutput("mem_addr_held", 32'(mem_addr), 32'(prev_addr));
      end
      prev_wait  = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      prev_reset = reset;
      if (!reset && retired) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_retire: got retire at pc %0h, required none", pc_o);
        end else begin
          e = exp_q.pop_front();
          checkOutput("illegal_op", 32'(illegal_op), 32'(e.illegal));
          checkOutput("latency", 32'(cyc - last_mark), 32'(e.lat));
          checkOutput("mem_we_at_retire", 32'(mem_we), 32'(e.is_st));
          if (e.is_st) begin
            checkOutput("store_addr", 32'(mem_addr), 32'(e.waddr));
            checkOutput("store_data", mem_wdata, e.wdata);
          end
          pc_exp     = e.pc;
          pc_pending = 1'b1;
        end
        last_mark = cyc;
      end
    end
  end

  // Stimulus: three programs separated by resets
  initial begin
    loadNops();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset_retired", 32'(retired), 32'd0);
    checkOutput("reset_illegal", 32'(illegal_op), 32'd0);
    checkOutput("reset_pc", 32'(pc_o), 32'd0);

    // ALU program, zero-wait memory
    applyStimulus( 0, 32'h2001_0005, 0,  4, 4, 0, 0,    0);            // addi $1,$0,5
    applyStimulus( 4, 32'hAC01_0080, 0,  8, 4, 1, 8'h80, 32'd5);       // sw $1,0x80
    applyStimulus( 8, 32'h2001_0007, 0, 12, 4, 0, 0,    0);            // addi $1,$0,7
    applyStimulus(12, 32'h2002_FFFD, 0, 16, 4, 0, 0,    0);            // addi $2,$0,-3
    applyStimulus(16, 32'h0022_1820, 0, 20, 4, 0, 0,    0);            // add $3,$1,$2
    applyStimulus(20, 32'h0041_202A, 0, 24, 4, 0, 0,    0);            // slt $4,$2,$1
    applyStimulus(24, 32'h0041_2822, 0, 28, 4, 0, 0,    0);            // sub $5,$2,$1
    applyStimulus(28, 32'h0022_3824, 0, 32, 4, 0, 0,    0);            // and $7,$1,$2
    applyStimulus(32, 32'h0022_4025, 0, 36, 4, 0, 0,    0);            // or  $8,$1,$2
    applyStimulus(36, 32'hAC03_0084, 0, 40, 4, 1, 8'h84, 32'd4);       // sw $3
    applyStimulus(40, 32'hAC04_0088, 0, 44, 4, 1, 8'h88, 32'd1);       // sw $4
    applyStimulus(44, 32'hAC05_008C, 0, 48, 4, 1, 8'h8C, 32'hFFFF_FFF6); // sw $5
    applyStimulus(48, 32'hAC07_0098, 0, 52, 4, 1, 8'h98, 32'd5);       // sw $7
    applyStimulus(52, 32'hAC08_009C, 0, 56, 4, 1, 8'h9C, 32'hFFFF_FFFF); // sw $8
    applyStimulus(56, 32'h2000_0009, 0, 60, 4, 0, 0,    0);            // addi $0,$0,9
    applyStimulus(60, 32'hAC00_0090, 0, 64, 4, 1, 8'h90, 32'd0);       // sw $0
    applyStimulus(64, 32'h0022_183F, 1, 68, 2, 0, 0,    0);            // funct 0x3F
    applyStimulus(68, 32'hAC03_0094, 0, 72, 4, 1, 8'h94, 32'd4);       // sw $3 after illegal
    releaseReset();
    waitDrain("alu_program");
    enterReset();

    // Load/store program with data accesses 3 cycles late
    loadNops();
    data_delay = 3;
    applyStimulus( 0, 32'h2001_0007, 0,  4, 4, 0, 0,    0);            // addi $1,$0,7
    applyStimulus( 4, 32'hAC01_0060, 0,  8, 7, 1, 8'h60, 32'd7);       // sw $1,0x60
    applyStimulus( 8, 32'h8C06_0060, 0, 12, 8, 0, 0,    0);            // lw $6,0x60
    applyStimulus(12, 32'hAC06_0064, 0, 16, 7, 1, 8'h64, 32'd7);       // sw $6,0x64
    mem[4] = 32'hAC01_0068;                                            // sw $1,0x68 (aborted)
    releaseReset();
    waitDrain("mem_program");
    begin
      int found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
        @(negedge clk);
        if (mem_req && mem_we && !mem_ready) found = 1;
      end
      if (found == 0) begin
        n_checks++;
        $display("[TB] FAIL mem_wr_wait_timeout: store wait not seen, required within 50 cycles");
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
    checkOutput("abort_mem_we", 32'(mem_we), 32'd0);
    checkOutput("abort_retired", 32'(retired), 32'd0);
    checkOutput("abort_pc", 32'(pc_o), 32'd0);

    // Post-abort program: registers cleared, then beq $1,$1,-1
    loadNops();
    data_delay = 0;
    applyStimulus(0, 32'hAC01_0070, 0, 4, 4, 1, 8'h70, 32'd0);         // sw $1,0x70
`ifdef MIPS_BRANCH_EN
    applyStimulus(4, 32'h1021_FFFF, 0, 4, 3, 0, 0, 0);
`else
    applyStimulus(4, 32'h1021_FFFF, 1, 8, 2, 0, 0, 0);
`endif
    releaseReset();
    waitDrain("branch_program");
    enterReset();

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
